fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Frontend stage directly upstream of the decode stage. Owns the PC and issues instruction-memory reads.
//  Buffers returned words in a small FIFO and presents {instr2, pc2} to decode each cycle.
//  Applies pcselect redirects (branch/jal/jalr) with flush of buffered and in-flight fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  2              instruction buffer entries (power of 2, >=2)
// PORTS
//  clk          in   1   clock, rising edge
//  nrst         in   1   reset, asynchronous, active-low
//  stall        in   1   decode cannot accept; hold instr2/pc2/valid2
//  pcselect     in   2   next-PC source: 0 seq, 1 branch, 2 jal, 3 jalr
//  btaken       in   1   branch resolved taken (qualifies pcselect==1)
//  pc_base      in   32  PC of the redirecting instruction (pc3)
//  b_imm        in   32  sign-extended B immediate
//  j_imm        in   32  sign-extended J immediate
//  i_imm        in   32  sign-extended I immediate
//  rs1_data     in   32  rs1 operand for jalr
//  imem_req     out  1   single-cycle read request; memory always accepts
//  imem_addr    out  32  word address of request
//  imem_rvalid  in   1   read data valid, >=1 cycle after imem_req
//  imem_rdata   in   32  instruction word
//  instr2       out  32  instruction to decode (NOP 32'h0000_0013 when !valid2)
//  pc2          out  32  PC of instr2 (0 when !valid2)
//  valid2       out  1   instr2/pc2 hold a real fetched instruction
//  misalign     out  1   one-cycle pulse: redirect target bit[1] set
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, FIFO empty, state ISSUE, discard=0; imem_req=0, imem_addr=RESET_PC,
//   instr2=NOP, pc2=0, valid2=0, misalign=0. All outputs registered or derived from FIFO head.
//  Redirect (redir) = pcselect==2 | pcselect==3 | (pcselect==1 & btaken). Target:
//   1: pc_base+b_imm; 2: pc_base+j_imm; 3: (rs1_data+i_imm)&~32'h1. Modulo-2^32 adds.
//  FSM, at most one request outstanding:
//   ISSUE: if !redir & (count + 0) < FIFO_DEPTH -> imem_req=1, imem_addr=fetch_pc, go WAIT.
//   WAIT: on imem_rvalid: discard? drop word, clear discard : push {fetch_pc, imem_rdata},
//    fetch_pc+=4; go ISSUE.
//  Redirect in any state: fetch_pc<=target, FIFO flushed (count=0), valid2=0 next cycle, no req that cycle.
//   In WAIT without rvalid: stay WAIT, discard<=1. In WAIT with rvalid same cycle: word dropped, go ISSUE.
//   Redirect while discard already set: discard stays 1, fetch_pc updated to newest target.
//  Latency: rvalid at cycle N -> valid2 at N+1 when FIFO was empty. Next req earliest N+1.
//  Pop when valid2 & !stall. Push and pop same cycle allowed at any count, incl. full.
//  Space check counts the outstanding request, so a response never overflows the FIFO.
//  Pointers wrap modulo FIFO_DEPTH.
//  stall & redir same cycle: redirect wins (flush).
//  Reset mid-operation: async clear of all state. Any later rvalid for a pre-reset request is
//   ignored, because state is ISSUE.
//  misalign: registered pulse, cycle after a redirect with target[1]==1. Redirect still taken.
// STRUCTURE
//  gpcore_pkg: pcsel_t enum {PC_SEQ=0, PC_BRANCH=1, PC_JAL=2, PC_JALR=3}, NOP_INSTR=32'h0000_0013,
//   fetch_state_t {ISSUE, WAIT}.
//  Sub-module fetch_fifo (DEPTH, 64-bit entries {pc,instr}, push/pop/flush, count, head).
//  Top: PC/FSM/discard logic plus target adder.
// TESTING
//  1. Reset, rvalid 1 cycle after each req, no stall -> reqs at 0x0,0x4,0x8; valid2 with pc2=0x0 one cycle after first rvalid.
//  2. stall held 6 cycles -> FIFO fills to 2, imem_req stays 0; instr2/pc2 stable; release -> pops in order, fetch resumes.
//  3. pcselect=2, pc_base=0x10, j_imm=0x20 -> valid2=0 next cycle, next req addr 0x30, FIFO empty.
//  4. pcselect=1, btaken=0 -> no redirect, sequential fetch continues; btaken=1, b_imm=-8 from 0x40 -> req 0x38.
//  5. jalr while WAIT, rvalid 3 cycles later: rs1=0x101, i_imm=0x4 -> stale word dropped, next req 0x104, valid2 never shows stale word.
//  6. jalr target 0x102 -> misalign pulses 1 cycle, req addr 0x102; nrst low mid-WAIT -> outputs to reset values immediately.

Source files
------------

// File: rtl/gpcore_pkg.sv
// Shared frontend types, constants and next-PC helpers.
package gpcore_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned ENTRY_W = 2 * XLEN;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JAL    = 2'd2,
      PC_JALR   = 2'd3
   } pcsel_t;

   typedef enum logic {
      ISSUE = 1'b0,
      WAIT  = 1'b1
   } fetch_state_t;

   // One buffered fetch: PC in the upper half, instruction word in the lower half.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // A branch only redirects when resolved taken; jumps always redirect.
   function automatic logic is_redirect(input pcsel_t sel, input logic btaken);
      return (sel == PC_JAL) || (sel == PC_JALR) || ((sel == PC_BRANCH) && btaken);
   endfunction

   // Redirect target, modulo-2^32; jalr clears bit 0.
   function automatic logic [XLEN-1:0] redirect_target(
      input pcsel_t          sel,
      input logic [XLEN-1:0] pc_base,
      input logic [XLEN-1:0] b_imm,
      input logic [XLEN-1:0] j_imm,
      input logic [XLEN-1:0] i_imm,
      input logic [XLEN-1:0] rs1_data
   );
      logic [XLEN-1:0] t;
      t = '0;
      case (sel)
         PC_BRANCH: t = pc_base + b_imm;
         PC_JAL:    t = pc_base + j_imm;
         PC_JALR:   t = (rs1_data + i_imm) & ~32'h1;
         default:   t = '0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: single-cycle request, later read-data valid.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Small instruction buffer between the fetch FSM and decode; flush has priority.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [$clog2(DEPTH):0] count,
   output logic [WIDTH-1:0]       head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // A push into a full buffer is only legal when the head leaves the same cycle.
   always_comb begin
      full    = (count == CNT_W'(DEPTH));
      do_pop  = pop && (count != '0) && !flush;
      do_push = push && (!full || do_pop) && !flush;
   end

   assign head = mem[rd_ptr];

   // Storage write; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Frontend fetch: owns the PC, issues imem reads, buffers words for decode, handles redirects.
module fetch_stage
   import gpcore_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               stall,
   input  logic [1:0]         pcselect,
   input  logic               btaken,
   input  logic [31:0]        pc_base,
   input  logic [31:0]        b_imm,
   input  logic [31:0]        j_imm,
   input  logic [31:0]        i_imm,
   input  logic [31:0]        rs1_data,
   fetch_stage_if.master      imem,
   output logic [31:0]        instr2,
   output logic [31:0]        pc2,
   output logic               valid2,
   output logic               misalign
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t     state;
   logic [31:0]      fetch_pc;
   logic             discard;
   logic             redir;
   logic [31:0]      target;
   logic [CNT_W-1:0] count;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;
   logic             push;
   logic             pop;
   logic             can_issue;

   // Redirect decode, target adder and FIFO handshakes.
   always_comb begin
      redir      = is_redirect(pcsel_t'(pcselect), btaken);
      target     = redirect_target(pcsel_t'(pcselect), pc_base, b_imm, j_imm, i_imm, rs1_data);
      push       = (state == WAIT) && imem.imem_rvalid && !discard && !redir;
      pop        = valid2 && !stall;
      can_issue  = (state == ISSUE) && !redir && (count < CNT_W'(FIFO_DEPTH));
      push_entry = '{pc: fetch_pc, instr: imem.imem_rdata};
   end

   // Decode-facing view of the buffer head.
   always_comb begin
      valid2 = (count != '0);
      instr2 = valid2 ? head.instr : NOP_INSTR;
      pc2    = valid2 ? head.pc    : '0;
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (push),
      .pop   (pop),
      .flush (redir),
      .wdata (push_entry),
      .count (count),
      .head  (head)
   );

   // Fetch FSM: one outstanding request; a redirect while waiting marks the response stale.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state          <= ISSUE;
         fetch_pc       <= RESET_PC;
         discard        <= 1'b0;
         imem.imem_req  <= 1'b0;
         imem.imem_addr <= RESET_PC;
         misalign       <= 1'b0;
      end else begin
         imem.imem_req <= 1'b0;
         misalign      <= redir && target[1];
         case (state)
            ISSUE: begin
               if (redir) begin
                  fetch_pc <= target;
               end else if (can_issue) begin
                  imem.imem_req  <= 1'b1;
                  imem.imem_addr <= fetch_pc;
                  state          <= WAIT;
               end
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  state   <= ISSUE;
                  discard <= 1'b0;
                  if (redir)         fetch_pc <= target;
                  else if (!discard) fetch_pc <= fetch_pc + 32'd4;
               end else if (redir) begin
                  fetch_pc <= target;
                  discard  <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: responding memory, queue-based reference model, directed scenarios.
module tb_fetch_stage;
   import gpcore_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          DEPTH  = 2;

   logic        clk      = 1'b0;
   logic        nrst     = 1'b0;
   logic        stall    = 1'b0;
   logic [1:0]  pcselect = 2'd0;
   logic        btaken   = 1'b0;
   logic [31:0] pc_base  = '0;
   logic [31:0] b_imm    = '0;
   logic [31:0] j_imm    = '0;
   logic [31:0] i_imm    = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] instr2;
   logic [31:0] pc2;
   logic        valid2;
   logic        misalign;

   fetch_stage_if imem_bus ();

   fetch_stage #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .stall    (stall),
      .pcselect (pcselect),
      .btaken   (btaken),
      .pc_base  (pc_base),
      .b_imm    (b_imm),
      .j_imm    (j_imm),
      .i_imm    (i_imm),
      .rs1_data (rs1_data),
      .imem     (imem_bus),
      .instr2   (instr2),
      .pc2      (pc2),
      .valid2   (valid2),
      .misalign (misalign)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Memory contents: every address holds a distinct word.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory: answers each request mem_lat cycles after it is seen.
   int          mem_lat   = 1;
   bit          pend      = 1'b0;
   int          pend_cnt  = 0;
   logic [31:0] pend_addr = '0;

   initial begin
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = '0;
   end

   always @(posedge clk) begin
      #1;
      imem_bus.imem_rvalid = 1'b0;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata  = mem_word(pend_addr);
            pend = 1'b0;
         end
      end
      if (imem_bus.imem_req) begin
         pend      = 1'b1;
         pend_cnt  = mem_lat;
         pend_addr = imem_bus.imem_addr;
      end
   end

   // Reference model: stream of fetched words as a queue, plus next fetch address.
   logic [63:0] mq[$];
   logic [31:0] reqlog[$];
   logic [31:0] next_fetch = RST_PC;
   logic [31:0] out_addr   = '0;
   bit          outst      = 1'b0;
   bit          stale      = 1'b0;
   bit          prev_redir = 1'b0;
   bit          exp_mis    = 1'b0;
   int          prev_qsize = 0;

   function automatic bit tb_redir();
      return (pcselect == 2'd2) || (pcselect == 2'd3) || ((pcselect == 2'd1) && btaken);
   endfunction

   function automatic logic [31:0] tb_target();
      case (pcselect)
         2'd1:    return pc_base + b_imm;
         2'd2:    return pc_base + j_imm;
         2'd3:    return (rs1_data + i_imm) & 32'hFFFF_FFFE;
         default: return 32'h0;
      endcase
   endfunction

   always @(negedge clk) begin
      bit          rd;
      logic [31:0] tg;
      if (!nrst) begin
         chk("rst_req",   32'(imem_bus.imem_req), 32'd0);
         chk("rst_addr",  imem_bus.imem_addr, RST_PC);
         chk("rst_valid", 32'(valid2), 32'd0);
         chk("rst_instr", instr2, NOP_INSTR);
         chk("rst_pc2",   pc2, 32'd0);
         chk("rst_mis",   32'(misalign), 32'd0);
         mq.delete();
         next_fetch = RST_PC;
         outst      = 1'b0;
         stale      = 1'b0;
         prev_redir = 1'b0;
         exp_mis    = 1'b0;
         prev_qsize = 0;
      end else begin
         chk("valid2", 32'(valid2), 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            chk("pc2",    pc2,    mq[0][63:32]);
            chk("instr2", instr2, mq[0][31:0]);
         end else begin
            chk("instr2_nop", instr2, NOP_INSTR);
            chk("pc2_zero",   pc2,    32'd0);
         end
         chk("misalign", 32'(misalign), 32'(exp_mis));
         if (prev_redir) chk("no_req_after_redir", 32'(imem_bus.imem_req), 32'd0);
         if (imem_bus.imem_req) begin
            reqlog.push_back(imem_bus.imem_addr);
            chk("req_addr",   imem_bus.imem_addr, next_fetch);
            chk("req_single", 32'(outst), 32'd0);
            chk("req_space",  32'(prev_qsize < DEPTH), 32'd1);
            outst    = 1'b1;
            stale    = 1'b0;
            out_addr = imem_bus.imem_addr;
         end
         prev_qsize = mq.size();
         rd = tb_redir();
         tg = tb_target();
         if ((mq.size() != 0) && !stall) void'(mq.pop_front());
         if (imem_bus.imem_rvalid && outst) begin
            outst = 1'b0;
            if (!stale && !rd) begin
               mq.push_back({out_addr, imem_bus.imem_rdata});
               next_fetch = out_addr + 32'd4;
            end
         end
         if (rd) begin
            mq.delete();
            next_fetch = tg;
            if (outst) stale = 1'b1;
         end
         if (mq.size() > DEPTH) chk("fifo_bound", 32'(mq.size()), 32'(DEPTH));
         exp_mis    = rd && tg[1];
         prev_redir = rd;
      end
   end

   // Stimulus helpers: inputs change 2 time units after the rising edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_req(input string name, input logic [31:0] exp, input int budget);
      int k = 0;
      while (!imem_bus.imem_req && k < budget) begin
         cyc(1);
         k++;
      end
      if (imem_bus.imem_req) chk(name, imem_bus.imem_addr, exp);
      else chk({name, "_timeout"}, 32'(imem_bus.imem_req), 32'd1);
   endtask

   task automatic wait_rvalid(input string name, input int budget);
      int k = 0;
      while (!imem_bus.imem_rvalid && k < budget) begin
         cyc(1);
         k++;
      end
      if (!imem_bus.imem_rvalid) chk({name, "_timeout"}, 32'(imem_bus.imem_rvalid), 32'd1);
   endtask

   task automatic redirect(input logic [1:0] sel, input logic bt, input logic [31:0] base,
                           input logic [31:0] bi, input logic [31:0] ji,
                           input logic [31:0] ii, input logic [31:0] rs1);
      pcselect = sel;
      btaken   = bt;
      pc_base  = base;
      b_imm    = bi;
      j_imm    = ji;
      i_imm    = ii;
      rs1_data = rs1;
      cyc(1);
      pcselect = 2'd0;
      btaken   = 1'b0;
   endtask

   initial begin
      int n;
      cyc(3);
      nrst = 1'b1;

      // Sequential fetch after reset.
      wait_rvalid("t1_rvalid", 10);
      cyc(1);
      chk("t1_valid2", 32'(valid2), 32'd1);
      chk("t1_pc2",    pc2, 32'h0);
      chk("t1_instr2", instr2, mem_word(32'h0));
      cyc(10);
      chk("t1_nreq", 32'(reqlog.size() >= 3), 32'd1);
      if (reqlog.size() >= 3) begin
         chk("t1_req0", reqlog[0], 32'h0);
         chk("t1_req1", reqlog[1], 32'h4);
         chk("t1_req2", reqlog[2], 32'h8);
      end

      // Stall together with a jal: redirect wins, then the buffer fills and fetch pauses.
      stall = 1'b1;
      redirect(2'd2, 1'b0, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0);
      cyc(8);
      n = reqlog.size();
      cyc(2);
      chk("t2_valid2", 32'(valid2), 32'd1);
      chk("t2_pc2",    pc2, 32'h200);
      chk("t2_instr2", instr2, mem_word(32'h200));
      chk("t2_noreq",  32'(imem_bus.imem_req), 32'd0);
      chk("t2_reqcnt", 32'(reqlog.size()), 32'(n));
      stall = 1'b0;
      cyc(1);
      chk("t2_pop_pc2", pc2, 32'h204);
      wait_req("t2_resume", 32'h208, 10);

      // jal: pc_base 0x10 + 0x20.
      redirect(2'd2, 1'b0, 32'h10, 32'h0, 32'h20, 32'h0, 32'h0);
      chk("t3_valid2", 32'(valid2), 32'd0);
      chk("t3_noreq",  32'(imem_bus.imem_req), 32'd0);
      wait_req("t3_req", 32'h30, 10);

      // Branch not taken keeps sequence; taken goes to 0x40-8.
      redirect(2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0);
      wait_req("t4_jal", 32'h40, 10);
      redirect(2'd1, 1'b0, 32'h40, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0);
      wait_req("t4_nt", 32'h44, 10);
      redirect(2'd1, 1'b1, 32'h40, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0);
      wait_req("t4_taken", 32'h38, 10);

      // jalr while a slow response is outstanding: stale word must vanish.
      mem_lat = 3;
      cyc(1);
      wait_req("t5_pre", 32'h3C, 10);
      redirect(2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h101);
      chk("t5_valid2", 32'(valid2), 32'd0);
      wait_req("t5_req", 32'h104, 15);
      cyc(1);
      wait_rvalid("t5_rvalid", 10);
      cyc(1);
      chk("t5_valid2b", 32'(valid2), 32'd1);
      chk("t5_pc2",     pc2, 32'h104);

      // Misaligned jalr target, then reset in the middle of a wait.
      mem_lat = 1;
      redirect(2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h101);
      chk("t6_mis_hi", 32'(misalign), 32'd1);
      cyc(1);
      chk("t6_mis_lo", 32'(misalign), 32'd0);
      wait_req("t6_req", 32'h102, 10);
      mem_lat = 3;
      cyc(1);
      wait_req("t6_pre", 32'h106, 10);
      #1;
      nrst = 1'b0;
      #1;
      chk("t6_rst_req",   32'(imem_bus.imem_req), 32'd0);
      chk("t6_rst_addr",  imem_bus.imem_addr, RST_PC);
      chk("t6_rst_valid", 32'(valid2), 32'd0);
      chk("t6_rst_instr", instr2, NOP_INSTR);
      chk("t6_rst_pc2",   pc2, 32'd0);
      chk("t6_rst_mis",   32'(misalign), 32'd0);
      cyc(5);
      nrst = 1'b1;
      wait_req("t6_post", RST_PC, 10);
      cyc(8);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
